// File: rtl/cache_miss_ctrl_pkg.sv
// Shared constants and state encoding for the cache miss/eviction sequencer.
package cache_miss_ctrl_pkg;

    localparam int WORD_W         = 32;
    localparam int ADDR_W         = 32;
    localparam int DEF_LINE_WORDS = 16;
    localparam int DEF_LINE_WIDTH = DEF_LINE_WORDS * WORD_W;
    localparam int DEF_INDEX_W    = 6;
    localparam int DEF_OFFSET_W   = 6;
    localparam int LEN_W          = 8;

    typedef enum logic [3:0] {
        ST_RUN,
        ST_WB_RD,
        ST_WB_CAP,
        ST_WB_REQ,
        ST_WB_DATA,
        ST_WB_RESP,
        ST_RF_REQ,
        ST_RF_DATA,
        ST_REFRESH,
        ST_REPLAY,
        ST_UC_REQ,
        ST_UC_RD,
        ST_UC_WR,
        ST_UC_RESP
    } state_e;

endpackage

// File: rtl/cache_line_buf.sv
// One-line staging buffer: whole-line load from the data array, word-indexed
// refill writes, and a word-indexed read port feeding write-back beats.
module cache_line_buf
    import cache_miss_ctrl_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int LINE_WIDTH = LINE_WORDS * WORD_W,
    parameter int BEAT_W     = $clog2(LINE_WORDS)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load_en_i,
    input  logic [LINE_WIDTH-1:0] load_line_i,
    input  logic                  wr_en_i,
    input  logic [BEAT_W-1:0]     wr_idx_i,
    input  logic [WORD_W-1:0]     wr_word_i,
    input  logic [BEAT_W-1:0]     rd_idx_i,
    output logic [WORD_W-1:0]     rd_word_o,
    output logic [LINE_WIDTH-1:0] line_o
);

    logic [LINE_WIDTH-1:0] line_q;

    // NOTE: this array is reset because it drives cacheline_new directly and
    // must read as zero out of reset; a pure storage RAM would skip the reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            line_q <= '0;
        end else if (load_en_i) begin
            line_q <= load_line_i;
        end else if (wr_en_i) begin
            line_q[wr_idx_i*WORD_W +: WORD_W] <= wr_word_i;
        end
    end

    assign rd_word_o = line_q[rd_idx_i*WORD_W +: WORD_W];
    assign line_o    = line_q;

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss/eviction sequencer: stalls on miss or uncached access, writes back a
// dirty victim, refills the line over the burst bus and pulses refresh.
module cache_miss_ctrl
    import cache_miss_ctrl_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int INDEX_W    = DEF_INDEX_W,
    parameter int OFFSET_W   = DEF_OFFSET_W
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  sram_en,
    input  logic [3:0]            sram_wen,
    input  logic [ADDR_W-1:0]     sram_addr,
    input  logic [WORD_W-1:0]     sram_wdata,
    input  logic [1:0]            hit,
    input  logic                  cached,
    input  logic                  lru,
    input  logic                  victim_dirty,
    input  logic [ADDR_W-INDEX_W-OFFSET_W-1:0] victim_tag,
    input  logic [LINE_WIDTH-1:0] cacheline_old,
    output logic                  stallreq,
    output logic                  write_back,
    output logic                  refresh,
    output logic                  refresh_way,
    output logic [LINE_WIDTH-1:0] cacheline_new,
    output logic [WORD_W-1:0]     uncached_rdata,
    output logic                  uncached_valid,
    output logic                  rd_req,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic [LEN_W-1:0]      rd_len,
    input  logic                  rd_ack,
    input  logic                  rd_valid,
    input  logic [WORD_W-1:0]     rd_data,
    output logic                  wr_req,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [LEN_W-1:0]      wr_len,
    input  logic                  wr_ack,
    output logic [WORD_W-1:0]     wr_data,
    output logic [3:0]            wr_strb,
    input  logic                  wr_beat_ready,
    input  logic                  wr_done
);

    localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam logic [LEN_W-1:0]  BURST_LEN = LEN_W'(LINE_WORDS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    state_e              state_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          wen_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                lru_q;
    logic [TAG_W-1:0]    victim_tag_q;

    logic                write_back_q;
    logic                refresh_q;
    logic [WORD_W-1:0]   uc_rdata_q;
    logic                uc_valid_q;
    logic                rd_req_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [LEN_W-1:0]    rd_len_q;
    logic                wr_req_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [LEN_W-1:0]    wr_len_q;
    logic [WORD_W-1:0]   wr_data_q;
    logic [3:0]          wr_strb_q;

    logic                buf_load;
    logic                buf_wr;
    logic [BEAT_W-1:0]   buf_rd_idx;
    logic [WORD_W-1:0]   buf_rd_word;
    logic                miss_now;

    // A refill beat lands either during the data phase or together with the ack.
    assign buf_load   = (state_q == ST_WB_CAP);
    assign buf_wr     = rd_valid & ((state_q == ST_RF_DATA) | ((state_q == ST_RF_REQ) & rd_ack));
    assign buf_rd_idx = (state_q == ST_WB_DATA) ? beat_q + BEAT_W'(1) : '0;

    cache_line_buf #(
        .LINE_WORDS (LINE_WORDS),
        .LINE_WIDTH (LINE_WIDTH),
        .BEAT_W     (BEAT_W)
    ) u_line_buf (
        .clk         (clk),
        .resetn      (resetn),
        .load_en_i   (buf_load),
        .load_line_i (cacheline_old),
        .wr_en_i     (buf_wr),
        .wr_idx_i    (beat_q),
        .wr_word_i   (rd_data),
        .rd_idx_i    (buf_rd_idx),
        .rd_word_o   (buf_rd_word),
        .line_o      (cacheline_new)
    );

    assign miss_now = sram_en & ((hit == 2'b00) | ~cached);
    assign stallreq = (state_q != ST_RUN) | miss_now;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_RUN;
            beat_q       <= '0;
            addr_q       <= '0;
            wen_q        <= '0;
            wdata_q      <= '0;
            lru_q        <= 1'b0;
            victim_tag_q <= '0;
            write_back_q <= 1'b0;
            refresh_q    <= 1'b0;
            uc_rdata_q   <= '0;
            uc_valid_q   <= 1'b0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            rd_len_q     <= '0;
            wr_req_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_len_q     <= '0;
            wr_data_q    <= '0;
            wr_strb_q    <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every branch below sees the
            // pre-edge state; the one-cycle strobes default low and are only
            // raised on the transition into their state.
            write_back_q <= 1'b0;
            refresh_q    <= 1'b0;
            uc_valid_q   <= 1'b0;

            unique case (state_q)
                ST_RUN: begin
                    if (miss_now) begin
                        addr_q       <= sram_addr;
                        wen_q        <= sram_wen;
                        wdata_q      <= sram_wdata;
                        lru_q        <= lru;
                        victim_tag_q <= victim_tag;
                        if (!cached) begin
                            state_q <= ST_UC_REQ;
                            if (sram_wen == 4'b0000) begin
                                rd_req_q  <= 1'b1;
                                rd_addr_q <= sram_addr;
                                rd_len_q  <= '0;
                            end else begin
                                wr_req_q  <= 1'b1;
                                wr_addr_q <= sram_addr;
                                wr_len_q  <= '0;
                            end
                        end else if (victim_dirty) begin
                            state_q      <= ST_WB_RD;
                            write_back_q <= 1'b1;
                        end else begin
                            state_q   <= ST_RF_REQ;
                            rd_req_q  <= 1'b1;
                            rd_addr_q <= {sram_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                            rd_len_q  <= BURST_LEN;
                            beat_q    <= '0;
                        end
                    end
                end

                ST_WB_RD: state_q <= ST_WB_CAP;

                ST_WB_CAP: begin
                    state_q   <= ST_WB_REQ;
                    wr_req_q  <= 1'b1;
                    wr_addr_q <= {victim_tag_q, addr_q[OFFSET_W +: INDEX_W], {OFFSET_W{1'b0}}};
                    wr_len_q  <= BURST_LEN;
                end

                ST_WB_REQ: begin
                    // A beat_ready coinciding with the ack is ignored; data starts next cycle.
                    if (wr_ack) begin
                        state_q   <= ST_WB_DATA;
                        wr_req_q  <= 1'b0;
                        beat_q    <= '0;
                        wr_data_q <= buf_rd_word;
                        wr_strb_q <= 4'hF;
                    end
                end

                ST_WB_DATA: begin
                    if (wr_beat_ready) begin
                        if (beat_q == LAST_BEAT) begin
                            state_q   <= ST_WB_RESP;
                            wr_data_q <= '0;
                            wr_strb_q <= '0;
                        end else begin
                            beat_q    <= beat_q + BEAT_W'(1);
                            wr_data_q <= buf_rd_word;
                        end
                    end
                end

                ST_WB_RESP: begin
                    if (wr_done) begin
                        state_q   <= ST_RF_REQ;
                        rd_req_q  <= 1'b1;
                        rd_addr_q <= {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        rd_len_q  <= BURST_LEN;
                        beat_q    <= '0;
                    end
                end

                ST_RF_REQ: begin
                    if (rd_ack) begin
                        state_q  <= ST_RF_DATA;
                        rd_req_q <= 1'b0;
                        beat_q   <= rd_valid ? BEAT_W'(1) : '0;
                    end
                end

                ST_RF_DATA: begin
                    if (rd_valid) begin
                        beat_q <= beat_q + BEAT_W'(1);
                        if (beat_q == LAST_BEAT) begin
                            state_q   <= ST_REFRESH;
                            refresh_q <= 1'b1;
                        end
                    end
                end

                ST_REFRESH: state_q <= ST_REPLAY;

                ST_REPLAY: state_q <= ST_RUN;

                ST_UC_REQ: begin
                    if (wen_q == 4'b0000) begin
                        if (rd_ack) begin
                            rd_req_q <= 1'b0;
                            if (rd_valid) begin
                                state_q    <= ST_RUN;
                                uc_rdata_q <= rd_data;
                                uc_valid_q <= 1'b1;
                            end else begin
                                state_q <= ST_UC_RD;
                            end
                        end
                    end else if (wr_ack) begin
                        state_q   <= ST_UC_WR;
                        wr_req_q  <= 1'b0;
                        wr_data_q <= wdata_q;
                        wr_strb_q <= wen_q;
                    end
                end

                ST_UC_RD: begin
                    if (rd_valid) begin
                        state_q    <= ST_RUN;
                        uc_rdata_q <= rd_data;
                        uc_valid_q <= 1'b1;
                    end
                end

                ST_UC_WR: begin
                    if (wr_beat_ready) begin
                        state_q   <= ST_UC_RESP;
                        wr_data_q <= '0;
                        wr_strb_q <= '0;
                    end
                end

                ST_UC_RESP: begin
                    if (wr_done) state_q <= ST_RUN;
                end

                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign write_back     = write_back_q;
    assign refresh        = refresh_q;
    assign refresh_way    = lru_q;
    assign uncached_rdata = uc_rdata_q;
    assign uncached_valid = uc_valid_q;
    assign rd_req         = rd_req_q;
    assign rd_addr        = rd_addr_q;
    assign rd_len         = rd_len_q;
    assign wr_req         = wr_req_q;
    assign wr_addr        = wr_addr_q;
    assign wr_len         = wr_len_q;
    assign wr_data        = wr_data_q;
    assign wr_strb        = wr_strb_q;

endmodule
